// File: rtl/ntt_stage_sequencer_if.sv
// Bundle between the transform controller, the stage sequencer and one core's
// RAM / twiddle-ROM / butterfly datapath.
interface ntt_stage_sequencer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int LANES      = 2,
  parameter int TW_WIDTH   = 12
);
  // start is a single-cycle request with no ready: it is taken only while the
  // sequencer is idle (busy=0, done=0) and dropped otherwise; done pulses once.
  logic                      start;
  logic [3:0]                log_m_first;
  logic [3:0]                stage_count;
  logic                      busy;
  logic                      done;
  logic [3:0]                cur_log_m;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      rd_select;
  logic [LANES*TW_WIDTH-1:0] tw_index;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic                      wr_select;

  modport master (
    output start, log_m_first, stage_count,
    input  busy, done, cur_log_m, rd_en, rd_addr, rd_select, tw_index,
    input  wr_en, wr_addr, wr_select
  );

  modport slave (
    input  start, log_m_first, stage_count,
    output busy, done, cur_log_m, rd_en, rd_addr, rd_select, tw_index,
    output wr_en, wr_addr, wr_select
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Multi-stage NTT/INTT sequencer: read sweep per stage, per-lane twiddle indices,
// delayed write-back addressing and ping-pong bank selection.
module ntt_stage_sequencer #(
  parameter int CORE_INDEX     = 0,
  parameter int LOG_CORE_COUNT = 4,
  parameter int ADDR_WIDTH     = 9,
  parameter int LANES          = 2,
  parameter int TW_WIDTH       = 12,
  parameter int PIPE_LAT       = 5,
  parameter int INVERSE        = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ntt_stage_sequencer_if.slave   bus,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);
  localparam int TWW = LANES * TW_WIDTH;

  state_t                             r_state;
  logic                               r_busy;
  logic                               r_done;
  logic [3:0]                         r_log_m;
  logic [3:0]                         r_remain;
  logic                               r_rd_en;
  logic [ADDR_WIDTH-1:0]              r_rd_addr;
  logic                               r_rd_select;
  logic [TWW-1:0]                     r_tw;
  logic [DW-1:0]                      r_drain;
  logic [PIPE_LAT-1:0]                r_dly_en;
  logic [PIPE_LAT-1:0][ADDR_WIDTH-1:0] r_dly_addr;

  logic [3:0]            w_next_log_m;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_next_log_m = (INVERSE != 0) ? r_log_m - 4'd1 : r_log_m + 4'd1;
  assign w_addr_inc   = r_rd_addr + 1'b1;

  // Twiddle base for this core at stage log_m, plus one consecutive index per lane.
  function automatic logic [TWW-1:0] tw_calc(input logic [3:0] m,
                                             input logic [ADDR_WIDTH-1:0] a);
    logic [31:0]    base;
    logic [31:0]    v;
    logic [TWW-1:0] res;
    base = (m == 4'd0) ? 32'd0 : (32'd1 << (m - 4'd1));
    base = base + ((32'(CORE_INDEX) << m) >> (LOG_CORE_COUNT + 1));
    res  = '0;
    for (int k = 0; k < LANES; k++) begin
      v = base + 32'(a) * 32'(LANES) + 32'(k);
      res[k*TW_WIDTH +: TW_WIDTH] = v[TW_WIDTH-1:0];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_log_m     <= '0;
      r_remain    <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_select <= 1'b0;
      r_tw        <= '0;
      r_drain     <= '0;
      r_dly_en    <= '0;
      r_dly_addr  <= '0;
    end else begin
      r_dly_en[0]   <= r_rd_en;
      r_dly_addr[0] <= r_rd_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dly_en[i]   <= r_dly_en[i-1];
        r_dly_addr[i] <= r_dly_addr[i-1];
      end
      r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_log_m   <= bus.log_m_first;
            r_remain  <= bus.stage_count;
            r_rd_addr <= '0;
            if (bus.stage_count == 4'd0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
              r_busy  <= 1'b1;
              r_rd_en <= 1'b1;
              r_tw    <= tw_calc(bus.log_m_first, '0);
            end
          end
        end
        READ: begin
          // The address wraps to 0 after the last word, ready for the next stage.
          r_rd_addr <= w_addr_inc;
          if (r_rd_addr == '1) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
            r_tw    <= '0;
            r_drain <= '0;
          end else begin
            r_tw <= tw_calc(r_log_m, w_addr_inc);
          end
        end
        DRAIN: begin
          if (r_drain == LAST_DRAIN) begin
            r_rd_select <= ~r_rd_select;
            r_remain    <= r_remain - 4'd1;
            r_log_m     <= w_next_log_m;
            if (r_remain == 4'd1) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= READ;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_tw      <= tw_calc(w_next_log_m, '0);
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cur_log_m = r_log_m;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.rd_select = r_rd_select;
  assign bus.tw_index  = r_tw;
  assign bus.wr_en     = r_dly_en[PIPE_LAT-1];
  assign bus.wr_addr   = r_dly_addr[PIPE_LAT-1];
  assign bus.wr_select = ~r_rd_select;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/ntt_stage_sequencer.md
# ntt_stage_sequencer

Parametrised stage sequencer for the NTT/INTT butterfly cores. It generates per-stage read addresses, per-lane twiddle-ROM indices, delayed write-back addresses/enables and ping-pong bank selects for a multi-stage transform. It generalises the fixed two-butterfly, externally-addressed core to LANES lanes, configurable pipeline latency and forward/inverse stage order. It sits between the top-level controller (start/done) and a core's RAMs, twiddle ROMs and butterflies.

## Interface
- CORE_INDEX, 0, index of this core, used in the twiddle offset
- LOG_CORE_COUNT, 4, log2 of the core count
- ADDR_WIDTH, 9, RAM address width; DEPTH = 2^ADDR_WIDTH words per stage
- LANES, 2, butterflies per core, each needing one twiddle per read
- TW_WIDTH, 12, twiddle index width
- PIPE_LAT, 5, cycles from read issue to write-back (RAM read, twiddle register, butterfly); must be ≥1
- INVERSE, 1, 0 = forward (log_m increments per stage), 1 = inverse (log_m decrements)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle start request
- log_m_first  in  4  log_m of the first stage
- stage_count  in  4  number of stages to run
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- cur_log_m  out  4  log_m of the stage currently reading
- rd_en  out  1  read issue
- rd_addr  out  ADDR_WIDTH  read address
- rd_select  out  1  read bank select
- tw_index  out  LANES*TW_WIDTH  twiddle indices, lane k in bits [k*TW_WIDTH +: TW_WIDTH]
- wr_en  out  1  write-back enable
- wr_addr  out  ADDR_WIDTH  write-back address
- wr_select  out  1  write bank select, always equal to ~rd_select

## Operation
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE: when start=1, latch log_m_first into cur_log_m and stage_count into a remaining-stage counter.
  - If stage_count=0, go to FIN.
  - Otherwise go to READ with the address counter at 0.
  - start while not in IDLE is ignored.
- READ: rd_en=1, rd_addr = counter, counter increments each cycle. After address DEPTH-1, go to DRAIN.
- DRAIN: rd_en=0 for PIPE_LAT cycles. On the last DRAIN cycle:
  - toggle rd_select;
  - decrement the remaining-stage counter;
  - step cur_log_m by +1 (INVERSE=0) or -1 (INVERSE=1), 4-bit wrap;
  - go to READ if stages remain, otherwise go to FIN.
- FIN: one cycle, done=1, busy=0, then IDLE.
- busy=1 in READ and DRAIN only.
- Twiddle index, lane k, while rd_en=1:
  - (1<<(cur_log_m-1)) + ((CORE_INDEX<<cur_log_m)>>(LOG_CORE_COUNT+1)) + rd_addr*LANES + k
  - result truncated to TW_WIDTH;
  - the first term is 0 when cur_log_m=0.
  - tw_index=0 when rd_en=0.
- Write-back: {rd_en, rd_addr} goes through a PIPE_LAT-deep shift register that drives {wr_en, wr_addr}.
- rd_select persists across runs and is not reset by start, so the result bank equals wr_select of the final stage.
- Reset (rst_n=0 at an edge, including mid-run): state IDLE, all outputs 0 (wr_select=1), delay line cleared. In-flight writes are dropped.

## Timing
- Reset values: busy=0, done=0, cur_log_m=0, rd_en=0, rd_addr=0, rd_select=0, tw_index=0, wr_en=0, wr_addr=0, wr_select=1.
- start at cycle 0 → first rd_en at cycle 1.
- Read at cycle r → matching write at cycle r+PIPE_LAT. The last write of a stage coincides with its last DRAIN cycle.
- Stage period = DEPTH+PIPE_LAT cycles.
- The next stage's first read is the cycle after the previous stage's last write, with the selects already toggled.
- done at cycle 1 + S*(DEPTH+PIPE_LAT) for stage_count=S>0; done at cycle 1 for S=0.
- start on the same cycle as done (FIN) is ignored. start is accepted from the following cycle.

## Test plan
Parameters unless stated: ADDR_WIDTH=2, PIPE_LAT=3, LANES=2, CORE_INDEX=3, LOG_CORE_COUNT=2, INVERSE=0.

- **Single stage:** start at cycle 0 with log_m_first=3, stage_count=1.
  - rd_addr 0,1,2,3 at cycles 1–4.
  - tw_index lanes (7,8), (9,10), (11,12), (13,14).
  - wr_addr 0–3 at cycles 4–7 with wr_select=1.
  - done at cycle 8; rd_select=1 afterwards.
- **Multi-stage forward:** log_m_first=2, stage_count=3.
  - cur_log_m 2, 3, 4 at cycles 1, 8, 15.
  - rd_select 0, 1, 0 per stage.
  - done at cycle 22; no read/write address overlap within any stage.
- **Inverse (INVERSE=1):** log_m_first=4, stage_count=2.
  - cur_log_m 4 then 3.
  - First stage lane-0 tw_index at addr 0 = 8+6 = 14.
  - done at cycle 15.
- **Start while busy:** start pulses at cycles 0 and 3, stage_count=1.
  - Exactly one run; done only at cycle 8.
  - Exactly 4 wr_en cycles.
- **Reset mid-run:** rst_n=0 at cycle 5 of a 2-stage run.
  - All outputs at reset values from the next edge.
  - No wr_en afterwards; a new start runs normally.
- **Zero stages:** stage_count=0.
  - done at cycle 1; rd_en and wr_en never assert; rd_select unchanged.
